// File: rtl/palette_bank_loader.sv
// Double-buffered palette RAM: the video path reads the active bank every cycle
// while a byte-stream loader fills the shadow bank, swapped only at vblank start.
module palette_bank_loader #(
  parameter int    ENTRIES   = 64,
  parameter string INIT_FILE = "",
  localparam int   IW        = $clog2(ENTRIES)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [IW-1:0] color,
  input  logic          vblank,
  output logic [14:0]   pixel,
  input  logic          load_start,
  input  logic          load_abort,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          busy,
  output logic          swap_pending,
  output logic          active_bank,
  output logic          load_done
);

  typedef enum logic [1:0] {IDLE, RECV_LO, RECV_HI, COMMIT} state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [7:0]    lo_q, lo_d;
  logic          active_bank_q, active_bank_d;
  logic          load_done_q, load_done_d;
  logic          vblank_q;
  logic [14:0]   pixel_q;

  logic          xfer;
  logic          vb_rise;
  logic          wr_en;
  logic [IW:0]   wr_addr;
  logic [14:0]   wr_data;
  logic          unused_in_data_msb;

  logic [14:0]   ram [2*ENTRIES];

  assign in_ready           = (state_q == RECV_LO) || (state_q == RECV_HI);
  assign busy               = (state_q != IDLE);
  assign swap_pending       = (state_q == COMMIT);
  assign active_bank        = active_bank_q;
  assign load_done          = load_done_q;
  assign pixel              = pixel_q;

  assign xfer               = in_valid & in_ready;
  assign vb_rise            = vblank & ~vblank_q;
  assign wr_addr            = {~active_bank_q, idx_q};
  assign wr_data            = {in_data[6:0], lo_q};
  assign unused_in_data_msb = in_data[7];

  // NOTE: every variable gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    lo_d          = lo_q;
    active_bank_d = active_bank_q;
    load_done_d   = 1'b0;
    wr_en         = 1'b0;

    case (state_q)
      IDLE: begin
        if (load_start && !load_abort) begin
          state_d = RECV_LO;
          idx_d   = '0;
        end
      end
      RECV_LO: begin
        if (load_abort) begin
          state_d = IDLE;
          idx_d   = '0;
        end else if (xfer) begin
          lo_d    = in_data;
          state_d = RECV_HI;
        end
      end
      RECV_HI: begin
        // Abort wins over a simultaneous transfer: the byte is neither consumed nor written.
        if (load_abort) begin
          state_d = IDLE;
          idx_d   = '0;
        end else if (xfer) begin
          wr_en = 1'b1;
          if (idx_q == IW'(ENTRIES - 1)) begin
            state_d = COMMIT;
          end else begin
            idx_d   = idx_q + IW'(1);
            state_d = RECV_LO;
          end
        end
      end
      COMMIT: begin
        if (load_abort) begin
          state_d = IDLE;
          idx_d   = '0;
        end else if (vb_rise) begin
          active_bank_d = ~active_bank_q;
          load_done_d   = 1'b1;
          state_d       = IDLE;
          idx_d         = '0;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      lo_q          <= '0;
      active_bank_q <= 1'b0;
      load_done_q   <= 1'b0;
      vblank_q      <= 1'b0;
      pixel_q       <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      lo_q          <= lo_d;
      active_bank_q <= active_bank_d;
      load_done_q   <= load_done_d;
      vblank_q      <= vblank;
      pixel_q       <= ram[{active_bank_q, color}];
    end
  end

  // NOTE: the RAM array has no reset so it maps onto block/distributed RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      ram[wr_addr] <= wr_data;
    end
  end

endmodule

// File: tb/tb_palette_bank_loader.sv
// Self-checking bench: control-vector table, directed load/swap/abort sequences and
// randomized byte pacing, all compared against a bank-array reference model.
module tb_palette_bank_loader;

  localparam int ENTRIES = 64;
  localparam int IW      = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [IW-1:0] color;
  logic          vblank;
  logic [14:0]   pixel;
  logic          load_start;
  logic          load_abort;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          busy;
  logic          swap_pending;
  logic          active_bank;
  logic          load_done;

  palette_bank_loader #(.ENTRIES(ENTRIES), .INIT_FILE("")) dut (
    .clk(clk), .rst_n(rst_n), .color(color), .vblank(vblank), .pixel(pixel),
    .load_start(load_start), .load_abort(load_abort), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .busy(busy),
    .swap_pending(swap_pending), .active_bank(active_bank), .load_done(load_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: two bank arrays, an active pointer, and a load phase with a byte count.
  logic [14:0] mref   [2][ENTRIES];
  bit          mknown [2][ENTRIES];
  int          m_mode;     // 0 idle, 1 receiving, 2 waiting for vblank
  int          m_n;        // bytes received in this load
  logic [7:0]  m_lo;
  bit          m_active;
  bit          m_prev_vb;
  int          xfer_count;

  logic [14:0] pat [ENTRIES];

  task automatic check(input string name, input logic [14:0] act, input logic [14:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode    = 0;
    m_n       = 0;
    m_active  = 1'b0;
    m_prev_vb = 1'b0;
  endtask

  // Advance one clock: predict from current inputs, then compare after the edge.
  task automatic step();
    bit          xfer, vbr, exp_done, pix_k;
    logic [14:0] pix_e;
    pix_k    = mknown[m_active][color];
    pix_e    = mref[m_active][color];
    xfer     = in_valid && (m_mode == 1);
    vbr      = vblank && !m_prev_vb;
    exp_done = 1'b0;
    case (m_mode)
      0: if (load_start && !load_abort) begin m_mode = 1; m_n = 0; end
      1: begin
        if (load_abort) m_mode = 0;
        else if (xfer) begin
          if (m_n % 2 == 0) m_lo = in_data;
          else begin
            mref[m_active ^ 1'b1][m_n/2]   = {in_data[6:0], m_lo};
            mknown[m_active ^ 1'b1][m_n/2] = 1'b1;
          end
          m_n++;
          xfer_count++;
          if (m_n == 2*ENTRIES) m_mode = 2;
        end
      end
      default: begin
        if (load_abort) m_mode = 0;
        else if (vbr) begin m_active = ~m_active; exp_done = 1'b1; m_mode = 0; end
      end
    endcase
    m_prev_vb = vblank;
    @(posedge clk);
    #1;
    check("in_ready", in_ready, m_mode == 1);
    check("busy", busy, m_mode != 0);
    check("swap_pending", swap_pending, m_mode == 2);
    check("active_bank", active_bank, m_active);
    check("load_done", load_done, exp_done);
    if (pix_k) check("pixel", pixel, pix_e);
  endtask

  function automatic logic [7:0] byte_of(input int k);
    logic [14:0] v;
    v = pat[k/2];
    if (k % 2 == 0) return v[7:0];
    return {1'($urandom_range(1)), v[14:8]};
  endfunction

  // Start a load and feed n_bytes with the given percentage of idle cycles.
  task automatic load(input int idle_pct, input int n_bytes);
    int budget;
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    xfer_count = 0;
    budget     = 0;
    while (xfer_count < n_bytes && budget < 3000) begin
      in_valid   = ($urandom_range(99) >= idle_pct);
      in_data    = byte_of(xfer_count);
      load_start = ($urandom_range(7) == 0);
      step();
      budget++;
    end
    in_valid   = 1'b0;
    load_start = 1'b0;
    check("load_within_budget", 15'(budget < 3000), 15'd1);
  endtask

  task automatic sweep();
    in_valid = 1'b0;
    for (int c = 0; c < ENTRIES; c++) begin
      color = IW'(c);
      step();
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  typedef struct {
    bit         start;
    bit         abort;
    bit         valid;
    logic [7:0] data;
    bit         exp_busy;
    bit         exp_ready;
  } vec_t;

  vec_t vecs [7];

  initial begin
    vecs[0] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0}; // start+abort in IDLE: stay idle
    vecs[1] = '{1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0}; // valid ignored while idle
    vecs[2] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1}; // start -> RECV_LO
    vecs[3] = '{1'b0, 1'b0, 1'b1, 8'h22, 1'b1, 1'b1}; // lo byte -> RECV_HI
    vecs[4] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1}; // start while busy ignored
    vecs[5] = '{1'b0, 1'b1, 1'b1, 8'h33, 1'b0, 1'b0}; // abort beats transfer
    vecs[6] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};

    rst_n = 1'b0; color = '0; vblank = 1'b0; load_start = 1'b0; load_abort = 1'b0;
    in_data = '0; in_valid = 1'b0;
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < ENTRIES; i++) mknown[b][i] = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_pixel", pixel, 15'h0);
    check("rst_active_bank", active_bank, 15'h0);
    check("rst_busy", busy, 15'h0);
    check("rst_in_ready", in_ready, 15'h0);
    check("rst_load_done", load_done, 15'h0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Control vector table
    for (int v = 0; v < 7; v++) begin
      load_start = vecs[v].start;
      load_abort = vecs[v].abort;
      in_valid   = vecs[v].valid;
      in_data    = vecs[v].data;
      step();
      check("vec_busy", busy, vecs[v].exp_busy);
      check("vec_in_ready", in_ready, vecs[v].exp_ready);
    end
    load_start = 1'b0; load_abort = 1'b0; in_valid = 1'b0;

    // Continuous load into bank1, swap on vblank rise
    for (int i = 0; i < ENTRIES; i++) pat[i] = 15'h4000 | 15'(i);
    load(0, 2*ENTRIES);
    check("full_xfers", 15'(xfer_count), 15'(2*ENTRIES));
    check("pending_after_last", swap_pending, 15'd1);
    in_valid = 1'b1;
    idle(4);
    in_valid = 1'b0;
    check("no_extra_xfers", 15'(xfer_count), 15'(2*ENTRIES));
    vblank = 1'b1;
    step();
    check("swap_bank1", active_bank, 15'd1);
    check("swap_done_pulse", load_done, 15'd1);
    step();
    check("done_one_cycle", load_done, 15'd0);
    vblank = 1'b0;
    color = 6'd63; step();
    check("pix63", pixel, 15'h403F);
    color = 6'd0; step();
    check("pix0", pixel, 15'h4000);

    // Randomly paced load into bank0 with the same pattern
    load(30, 2*ENTRIES);
    check("rand_xfers", 15'(xfer_count), 15'(2*ENTRIES));
    in_valid = 1'b1;
    idle(3);
    in_valid = 1'b0;
    check("rand_ready_low", in_ready, 15'd0);
    vblank = 1'b1; step(); vblank = 1'b0; step();
    check("swap_bank0", active_bank, 15'd0);
    for (int c = 0; c < ENTRIES; c++) begin
      color = IW'(c);
      step();
      check("pix_rand_load", pixel, 15'h4000 | 15'(c));
    end

    // Load while vblank already high: no swap until a fresh rising edge
    vblank = 1'b1;
    idle(2);
    for (int i = 0; i < ENTRIES; i++) pat[i] = 15'($urandom);
    load(10, 2*ENTRIES);
    idle(5);
    check("no_swap_vb_high", active_bank, 15'd0);
    sweep();
    vblank = 1'b0; step();
    vblank = 1'b1; step();
    check("swap_after_new_edge", active_bank, 15'd1);
    vblank = 1'b0;
    sweep();

    // Abort after 40 bytes, then a full restart
    for (int i = 0; i < ENTRIES; i++) pat[i] = 15'($urandom);
    load(20, 40);
    load_abort = 1'b1; step(); load_abort = 1'b0;
    check("abort_idle", busy, 15'd0);
    idle(2);
    for (int i = 0; i < ENTRIES; i++) pat[i] = 15'($urandom);
    load(0, 2*ENTRIES);
    vblank = 1'b1; step(); vblank = 1'b0; step();
    check("restart_swap", active_bank, 15'd0);
    sweep();

    // Abort coinciding with vblank rise in COMMIT
    load(0, 2*ENTRIES);
    vblank = 1'b1; load_abort = 1'b1;
    step();
    check("abort_vs_vb_bank", active_bank, 15'd0);
    check("abort_vs_vb_done", load_done, 15'd0);
    load_abort = 1'b0; vblank = 1'b0;
    idle(3);

    // Reset in the middle of a load
    load(0, 10);
    rst_n = 1'b0;
    #2;
    check("midrst_busy", busy, 15'd0);
    check("midrst_ready", in_ready, 15'd0);
    check("midrst_bank", active_bank, 15'd0);
    check("midrst_pixel", pixel, 15'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    sweep();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
